sprite_entity_engine: RTL and testbench

Parametrised multi-entity sprite engine for the play field: holds position, facing and motion state for up to NUM_ENT on-screen actors (player, enemies, projectiles), advances each actor's walk-cycle animation on frame ticks, and, for the current DrawX/DrawY, resolves which actor covers the pixel. It then emits the sprite-ROM read address, plus an on-flag and actor id aligned to the ROM's read latency. It sits between the movement logic (which writes actor state) and the shared sprite ROM / colour mapper.

---
 rtl/sprite_entity_engine.sv | 138 +++++++++++++
 tb/tb_sprite_entity_engine.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_entity_engine.sv
// sprite_entity_engine: per-slot actor state, walk-cycle animation and
// pixel-to-sprite-ROM address resolution with ROM-latency-aligned flags.
module sprite_entity_engine #(
  parameter int NUM_ENT   = 4,
  parameter int SPR_W     = 48,
  parameter int SPR_H     = 72,
  parameter int FRAMES    = 6,
  parameter int FRAME_DIV = 8,
  parameter int COORD_W   = 10,
  parameter int ADDR_W    = 17,
  parameter int ROM_LAT   = 1,
  localparam int SEL_W    = NUM_ENT > 1 ? $clog2(NUM_ENT) : 1
)(
  input  logic               Clk,
  input  logic               Reset,
  input  logic               frame_clk,
  input  logic               ent_we,
  input  logic [SEL_W-1:0]   ent_sel,
  input  logic [COORD_W-1:0] ent_x,
  input  logic [COORD_W-1:0] ent_y,
  input  logic               ent_active,
  input  logic               ent_moving,
  input  logic               ent_dir,
  input  logic [COORD_W-1:0] DrawX,
  input  logic [COORD_W-1:0] DrawY,
  output logic [ADDR_W-1:0]  rom_addr,
  output logic               sprite_on,
  output logic [SEL_W-1:0]   sprite_id
);
  localparam int FR_W = $clog2(FRAMES);
  localparam int DIV_W = FRAME_DIV > 1 ? $clog2(FRAME_DIV) : 1;
  localparam logic [COORD_W:0] W_EXT = (COORD_W+1)'(SPR_W);
  localparam logic [COORD_W:0] H_EXT = (COORD_W+1)'(SPR_H);
  localparam logic [COORD_W-1:0] COL_MAX = COORD_W'(SPR_W - 1);

  logic [COORD_W-1:0] posX [NUM_ENT];
  logic [COORD_W-1:0] posY [NUM_ENT];
  logic [NUM_ENT-1:0] isActive, isMoving, isLeft, hitVec;
  logic [DIV_W-1:0] divCnt [NUM_ENT];
  logic [FR_W-1:0] frameCnt [NUM_ENT];
  logic frameClkQ, tick;
  logic hit;
  logic [SEL_W-1:0] hitIdx;
  logic [COORD_W-1:0] offX, hitCol, hitRow;
  logic [FR_W-1:0] hitFrame;
  logic [ADDR_W-1:0] addrNext;
  logic onPipe [ROM_LAT+1];
  logic [SEL_W-1:0] idPipe [ROM_LAT+1];

  assign tick = frame_clk & ~frameClkQ;

  // Animation reads isMoving before this edge, so a same-cycle write only affects later ticks
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) begin
      frameClkQ <= 1'b0;
      isActive <= '0;
      isMoving <= '0;
      isLeft <= '0;
      for (int i = 0; i < NUM_ENT; i++) begin
        posX[i] <= '0;
        posY[i] <= '0;
        divCnt[i] <= '0;
        frameCnt[i] <= '0;
      end
    end else begin
      frameClkQ <= frame_clk;
      for (int i = 0; i < NUM_ENT; i++) begin
        if (ent_we && ent_sel == SEL_W'(i)) begin
          posX[i] <= ent_x;
          posY[i] <= ent_y;
          isActive[i] <= ent_active;
          isMoving[i] <= ent_moving;
          isLeft[i] <= ent_dir;
        end
        if (tick) begin
          if (!isMoving[i]) begin
            divCnt[i] <= '0;
            frameCnt[i] <= '0;
          end else if (frameCnt[i] == '0) begin
            divCnt[i] <= '0;
            frameCnt[i] <= FR_W'(1);
          end else if (divCnt[i] == DIV_W'(FRAME_DIV - 1)) begin
            divCnt[i] <= '0;
            frameCnt[i] <= frameCnt[i] == FR_W'(FRAMES - 1) ? FR_W'(1) : frameCnt[i] + 1'b1;
          end else
            divCnt[i] <= divCnt[i] + 1'b1;
        end
      end
    end

  // Extended-width bounds keep boxes near the coordinate limit from wrapping
  for (genvar g = 0; g < NUM_ENT; g++) begin : gHit
    assign hitVec[g] = isActive[g] && DrawX >= posX[g] && DrawY >= posY[g] &&
                       {1'b0, DrawX} < {1'b0, posX[g]} + W_EXT &&
                       {1'b0, DrawY} < {1'b0, posY[g]} + H_EXT;
  end

  always_comb begin
    hit = 1'b0;
    hitIdx = '0;
    offX = '0;
    hitCol = '0;
    hitRow = '0;
    hitFrame = '0;
    for (int i = NUM_ENT - 1; i >= 0; i--)
      if (hitVec[i]) begin
        hit = 1'b1;
        hitIdx = SEL_W'(i);
        offX = DrawX - posX[i];
        hitCol = isLeft[i] ? COL_MAX - offX : offX;
        hitRow = DrawY - posY[i];
        hitFrame = frameCnt[i];
      end
  end

  assign addrNext = ((ADDR_W'(hitIdx) * ADDR_W'(FRAMES) + ADDR_W'(hitFrame)) * ADDR_W'(SPR_H) +
                     ADDR_W'(hitRow)) * ADDR_W'(SPR_W) + ADDR_W'(hitCol);

  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) begin
      rom_addr <= '0;
      for (int k = 0; k <= ROM_LAT; k++) begin
        onPipe[k] <= 1'b0;
        idPipe[k] <= '0;
      end
    end else begin
      rom_addr <= addrNext;
      onPipe[0] <= hit;
      idPipe[0] <= hitIdx;
      for (int k = 1; k <= ROM_LAT; k++) begin
        onPipe[k] <= onPipe[k-1];
        idPipe[k] <= idPipe[k-1];
      end
    end

  assign sprite_on = onPipe[ROM_LAT];
  assign sprite_id = idPipe[ROM_LAT];
endmodule

// File: tb/tb_sprite_entity_engine.sv
// tb_sprite_entity_engine: directed and randomized checks of the sprite engine
// against a slot-level reference model.
module tb_sprite_entity_engine;
  localparam int NE = 4, SW = 48, SH = 72, FR = 6, FD = 8, CW = 10, AW = 17, RL = 1;

  logic Clk = 0, Reset = 0, frame_clk = 0, ent_we = 0, ent_active = 0, ent_moving = 0, ent_dir = 0;
  logic [1:0] ent_sel = 0;
  logic [CW-1:0] ent_x = 0, ent_y = 0, DrawX = 0, DrawY = 0;
  logic [AW-1:0] rom_addr;
  logic sprite_on;
  logic [1:0] sprite_id;
  logic ent_we5 = 0;
  logic [2:0] ent_sel5 = 0;
  logic [AW-1:0] rom_addr5;
  logic sprite_on5;
  logic [2:0] sprite_id5;

  int errors = 0, checks = 0;
  int mX[NE], mY[NE], mTicks[NE];
  bit mAct[NE], mMov[NE], mDir[NE], mFc;
  bit qOn[$];
  int qId[$];
  logic [AW-1:0] expAddr;
  logic expOn;
  logic [1:0] expId;

  always #5 Clk = ~Clk;

  sprite_entity_engine #(.NUM_ENT(NE), .SPR_W(SW), .SPR_H(SH), .FRAMES(FR), .FRAME_DIV(FD),
    .COORD_W(CW), .ADDR_W(AW), .ROM_LAT(RL)) dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .ent_we(ent_we), .ent_sel(ent_sel),
    .ent_x(ent_x), .ent_y(ent_y), .ent_active(ent_active), .ent_moving(ent_moving),
    .ent_dir(ent_dir), .DrawX(DrawX), .DrawY(DrawY), .rom_addr(rom_addr),
    .sprite_on(sprite_on), .sprite_id(sprite_id));

  // Five-slot instance so an out-of-range slot select is representable
  sprite_entity_engine #(.NUM_ENT(5), .SPR_W(SW), .SPR_H(SH), .FRAMES(FR), .FRAME_DIV(FD),
    .COORD_W(CW), .ADDR_W(AW), .ROM_LAT(RL)) dut5 (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .ent_we(ent_we5), .ent_sel(ent_sel5),
    .ent_x(ent_x), .ent_y(ent_y), .ent_active(ent_active), .ent_moving(ent_moving),
    .ent_dir(ent_dir), .DrawX(DrawX), .DrawY(DrawY), .rom_addr(rom_addr5),
    .sprite_on(sprite_on5), .sprite_id(sprite_id5));

  // A slot moving for n ticks shows frame 1 for FD ticks, then 2, ... cycling 1..FR-1
  function automatic int frame_of(input int i);
    return mTicks[i] == 0 ? 0 : 1 + ((mTicks[i] - 1) / FD) % (FR - 1);
  endfunction

  function automatic void model_pix(input int dx, input int dy, output int a, output bit on, output int id);
    a = 0;
    on = 0;
    id = 0;
    for (int i = 0; i < NE; i++)
      if (!on && mAct[i] && dx >= mX[i] && dx < mX[i] + SW && dy >= mY[i] && dy < mY[i] + SH) begin
        on = 1;
        id = i;
        a = ((i * FR + frame_of(i)) * SH + dy - mY[i]) * SW + (mDir[i] ? SW - 1 - (dx - mX[i]) : dx - mX[i]);
      end
  endfunction

  task automatic reset_model();
    foreach (mX[i]) begin
      mX[i] = 0; mY[i] = 0; mTicks[i] = 0; mAct[i] = 0; mMov[i] = 0; mDir[i] = 0;
    end
    mFc = 0;
    qOn.delete();
    qId.delete();
    repeat (RL) begin
      qOn.push_back(0);
      qId.push_back(0);
    end
  endtask

  // One clock: predict outputs for the current inputs, update the model, step past the edge
  task automatic cycle();
    int a, id;
    bit on;
    if (!Reset) begin
      reset_model();
      @(posedge Clk); #1;
      expAddr = '0; expOn = 0; expId = '0;
      return;
    end
    model_pix(int'(DrawX), int'(DrawY), a, on, id);
    qOn.push_back(on);
    qId.push_back(id);
    if (frame_clk && !mFc)
      for (int i = 0; i < NE; i++) mTicks[i] = mMov[i] ? mTicks[i] + 1 : 0;
    mFc = frame_clk;
    if (ent_we && int'(ent_sel) < NE) begin
      mX[ent_sel] = int'(ent_x); mY[ent_sel] = int'(ent_y);
      mAct[ent_sel] = ent_active; mMov[ent_sel] = ent_moving; mDir[ent_sel] = ent_dir;
    end
    @(posedge Clk); #1;
    expAddr = AW'(a);
    expOn = qOn.pop_front();
    expId = 2'(qId.pop_front());
  endtask

  task automatic write_ent(input int sel, input int x, input int y, input bit act, input bit mov, input bit dir);
    ent_we = 1; ent_sel = 2'(sel); ent_x = CW'(x); ent_y = CW'(y);
    ent_active = act; ent_moving = mov; ent_dir = dir;
    cycle();
    ent_we = 0;
  endtask

  task automatic tick();
    frame_clk = 1;
    cycle();
    frame_clk = 0;
    cycle();
  endtask

  task automatic pix(input int x, input int y);
    DrawX = CW'(x);
    DrawY = CW'(y);
    repeat (1 + RL) cycle();
  endtask

  task automatic test_reset();
    Reset = 0;
    for (int k = 0; k < 6; k++) begin
      DrawX = CW'($urandom); DrawY = CW'($urandom);
      cycle();
      checks++;
      if (rom_addr !== '0 || sprite_on !== 1'b0) begin
        errors++; $display("FAIL reset_hold addr=%0d on=%b want 0/0", rom_addr, sprite_on);
      end
    end
    Reset = 1;
    for (int k = 0; k < 4; k++) begin
      DrawX = CW'($urandom); DrawY = CW'($urandom);
      cycle();
      checks++;
      if (sprite_on !== 1'b0 || rom_addr !== '0) begin
        errors++; $display("FAIL reset_idle addr=%0d on=%b want 0/0", rom_addr, sprite_on);
      end
    end
  endtask

  task automatic test_single();
    int px[3] = '{100, 147, 148};
    int py[3] = '{50, 121, 50};
    int ea[3] = '{0, 3455, 0};
    bit eh[3] = '{1, 1, 0};
    int p;
    write_ent(0, 100, 50, 1, 0, 0);
    pix(0, 0);
    for (int c = 0; c < 3 + RL; c++) begin
      p = c < 3 ? c : 2;
      DrawX = CW'(px[p]); DrawY = CW'(py[p]);
      cycle();
      checks++;
      if (rom_addr !== AW'(ea[p]) || rom_addr !== expAddr) begin
        errors++; $display("FAIL single_addr step=%0d got=%0d want=%0d", c, rom_addr, ea[p]);
      end
      checks++;
      if (sprite_on !== (c >= RL ? eh[c - RL < 3 ? c - RL : 2] : 1'b0) || sprite_on !== expOn) begin
        errors++; $display("FAIL single_on step=%0d got=%b want=%b", c, sprite_on, expOn);
      end
    end
  endtask

  task automatic test_mirror();
    write_ent(0, 100, 50, 1, 0, 1);
    pix(100, 50);
    checks++;
    if (rom_addr !== 17'd47 || rom_addr !== expAddr || sprite_on !== 1'b1) begin
      errors++; $display("FAIL mirror addr=%0d on=%b want 47/1", rom_addr, sprite_on);
    end
  endtask

  task automatic test_animation();
    int want;
    write_ent(0, 100, 50, 1, 1, 0);
    pix(100, 50);
    checks++;
    if (rom_addr !== '0) begin
      errors++; $display("FAIL anim_start got=%0d want=0", rom_addr);
    end
    for (int t = 1; t <= 41; t++) begin
      tick();
      checks++;
      if (rom_addr !== expAddr || rom_addr == '0) begin
        errors++; $display("FAIL anim_tick t=%0d got=%0d want=%0d", t, rom_addr, expAddr);
      end
      if (t == 1 || t == 8 || t == 9 || t == 40 || t == 41) begin
        want = t == 9 ? 6912 : t == 40 ? 17280 : 3456;
        checks++;
        if (rom_addr !== AW'(want)) begin
          errors++; $display("FAIL anim_frame t=%0d got=%0d want=%0d", t, rom_addr, want);
        end
      end
    end
    write_ent(0, 100, 50, 1, 0, 0);
    tick();
    checks++;
    if (rom_addr !== '0) begin
      errors++; $display("FAIL anim_stop got=%0d want=0", rom_addr);
    end
  endtask

  task automatic test_same_cycle();
    ent_we = 1; ent_sel = 0; ent_x = 100; ent_y = 50; ent_active = 1; ent_moving = 1; ent_dir = 0;
    frame_clk = 1;
    cycle();
    ent_we = 0; frame_clk = 0;
    cycle();
    checks++;
    if (rom_addr !== '0 || rom_addr !== expAddr) begin
      errors++; $display("FAIL same_start got=%0d want=0", rom_addr);
    end
    tick();
    checks++;
    if (rom_addr !== 17'd3456) begin
      errors++; $display("FAIL same_next got=%0d want=3456", rom_addr);
    end
    ent_we = 1; ent_moving = 0; frame_clk = 1;
    cycle();
    ent_we = 0; frame_clk = 0;
    cycle();
    checks++;
    if (rom_addr !== 17'd3456 || rom_addr !== expAddr) begin
      errors++; $display("FAIL same_stop got=%0d want=3456", rom_addr);
    end
    tick();
    checks++;
    if (rom_addr !== '0) begin
      errors++; $display("FAIL same_idle got=%0d want=0", rom_addr);
    end
    write_ent(0, 100, 50, 1, 1, 0);
    frame_clk = 1;
    repeat (12) cycle();
    frame_clk = 0;
    cycle();
    checks++;
    if (rom_addr !== 17'd3456 || rom_addr !== expAddr) begin
      errors++; $display("FAIL held_high got=%0d want=3456", rom_addr);
    end
    write_ent(0, 100, 50, 1, 0, 0);
    tick();
  endtask

  task automatic test_priority();
    write_ent(1, 200, 100, 1, 0, 0);
    write_ent(3, 200, 100, 1, 0, 0);
    pix(200, 100);
    checks++;
    if (sprite_id !== 2'd1 || rom_addr !== 17'd20736 || sprite_on !== 1'b1) begin
      errors++; $display("FAIL prio_both id=%0d addr=%0d on=%b want 1/20736/1", sprite_id, rom_addr, sprite_on);
    end
    write_ent(1, 200, 100, 0, 0, 0);
    pix(200, 100);
    checks++;
    if (sprite_id !== 2'd3 || rom_addr !== 17'd62208 || sprite_id !== expId) begin
      errors++; $display("FAIL prio_one id=%0d addr=%0d want 3/62208", sprite_id, rom_addr);
    end
  endtask

  task automatic test_boundary();
    write_ent(2, 1000, 10, 1, 0, 0);
    pix(1023, 10);
    checks++;
    if (rom_addr !== 17'd41495 || sprite_id !== 2'd2 || sprite_on !== 1'b1) begin
      errors++; $display("FAIL edge_hit addr=%0d id=%0d want 41495/2", rom_addr, sprite_id);
    end
    pix(1023, 81);
    checks++;
    if (rom_addr !== 17'd44903 || rom_addr !== expAddr) begin
      errors++; $display("FAIL edge_corner addr=%0d want 44903", rom_addr);
    end
    pix(4, 10);
    checks++;
    if (sprite_on !== 1'b0 || rom_addr !== '0) begin
      errors++; $display("FAIL edge_nowrap on=%b addr=%0d want 0/0", sprite_on, rom_addr);
    end
    ent_x = 300; ent_y = 300; ent_active = 1; ent_moving = 0; ent_dir = 0;
    ent_we5 = 1; ent_sel5 = 5;
    cycle();
    ent_sel5 = 7;
    cycle();
    ent_we5 = 0;
    pix(300, 300);
    checks++;
    if (sprite_on5 !== 1'b0 || rom_addr5 !== '0) begin
      errors++; $display("FAIL sel_ignored on=%b addr=%0d want 0/0", sprite_on5, rom_addr5);
    end
    ent_we5 = 1; ent_sel5 = 4;
    cycle();
    ent_we5 = 0;
    pix(300, 300);
    checks++;
    if (sprite_on5 !== 1'b1 || sprite_id5 !== 3'd4 || rom_addr5 !== 17'd82944) begin
      errors++; $display("FAIL sel_top on=%b id=%0d addr=%0d want 1/4/82944", sprite_on5, sprite_id5, rom_addr5);
    end
  endtask

  task automatic test_back_to_back();
    int j, ox, oy;
    for (int n = 0; n < 1500; n++) begin
      ent_we = $urandom_range(0, 7) == 0;
      if (ent_we) begin
        ent_sel = 2'($urandom);
        ent_x = CW'($urandom_range(0, 1) ? $urandom_range(0, 1023) : $urandom_range(150, 250));
        ent_y = CW'($urandom_range(0, 1) ? $urandom_range(0, 1023) : $urandom_range(150, 250));
        ent_active = $urandom_range(0, 3) != 0;
        ent_moving = 1'($urandom);
        ent_dir = 1'($urandom);
      end
      if ($urandom_range(0, 2) == 0) frame_clk = ~frame_clk;
      j = $urandom_range(0, NE - 1);
      ox = int'($urandom_range(0, SW + 7)) - 4;
      oy = int'($urandom_range(0, SH + 7)) - 4;
      DrawX = CW'(mX[j] + ox);
      DrawY = CW'(mY[j] + oy);
      cycle();
      checks++;
      if (rom_addr !== expAddr) begin
        errors++; $display("FAIL rand_addr n=%0d got=%0d want=%0d", n, rom_addr, expAddr);
      end
      checks++;
      if (sprite_on !== expOn || sprite_id !== expId) begin
        errors++; $display("FAIL rand_flag n=%0d on=%b id=%0d want %b/%0d", n, sprite_on, sprite_id, expOn, expId);
      end
    end
    ent_we = 0;
    frame_clk = 0;
    cycle();
  endtask

  task automatic test_reset_mid();
    write_ent(0, 100, 50, 1, 1, 0);
    pix(100, 50);
    checks++;
    if (sprite_on !== 1'b1) begin
      errors++; $display("FAIL mid_pre on=%b want 1", sprite_on);
    end
    #2 Reset = 0;
    #1;
    checks++;
    if (rom_addr !== '0 || sprite_on !== 1'b0 || sprite_id !== '0) begin
      errors++; $display("FAIL mid_async addr=%0d on=%b id=%0d want 0", rom_addr, sprite_on, sprite_id);
    end
    cycle();
    Reset = 1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      checks++;
      if (sprite_on !== 1'b0 || rom_addr !== '0) begin
        errors++; $display("FAIL mid_after on=%b addr=%0d want 0/0", sprite_on, rom_addr);
      end
    end
  endtask

  initial begin
    reset_model();
    test_reset();
    test_single();
    test_mirror();
    test_animation();
    test_same_cycle();
    test_priority();
    test_boundary();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
